// File: rtl/ram_arbiter.sv
// Arbitrates a single-port RAM between an instruction-fetch port and a load/store port.
// Data wins by default; a fetch that has waited too long gets priority.
module ram_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [1:0]      d_wmode,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  input  logic            flush,
  output logic [XLEN-1:0] ram_addr,
  output logic [1:0]      ram_write_mode,
  output logic [XLEN-1:0] ram_wdata,
  input  logic [XLEN-1:0] ram_rdata,
  output logic            starved
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_D    = 2'b10
  } owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_t          r_owner;
  owner_t          w_owner_nxt;
  logic [3:0]      r_starve_cnt;
  logic [3:0]      w_starve_cnt_nxt;
  logic            r_starved;
  logic [XLEN-1:0] r_last_addr;
  logic            w_if_gnt;
  logic            w_d_gnt;
  logic [XLEN-1:0] w_ram_addr;
  logic [1:0]      w_ram_mode;
  logic [XLEN-1:0] w_ram_wdata;

  // Grant selection: at most one winner, held off entirely while in reset
  always_comb begin
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    if (!rst) begin
      w_if_gnt = 1'b0;
      w_d_gnt  = 1'b0;
    end else if (r_starved) begin
      if (if_req) begin
        w_if_gnt = 1'b1;
      end else begin
        w_d_gnt = d_req;
      end
    end else begin
      if (d_req) begin
        w_d_gnt = 1'b1;
      end else begin
        w_if_gnt = if_req;
      end
    end
  end

  // RAM port steering; the address is held from the last grant when idle
  always_comb begin
    w_ram_addr  = r_last_addr;
    w_ram_mode  = 2'b00;
    w_ram_wdata = {XLEN{1'b0}};
    if (w_d_gnt) begin
      w_ram_addr  = d_addr;
      w_ram_wdata = d_wdata;
      if (d_we) begin
        w_ram_mode = d_wmode;
      end else begin
        w_ram_mode = 2'b00;
      end
    end else if (w_if_gnt) begin
      w_ram_addr = if_addr;
    end else begin
      w_ram_addr = r_last_addr;
    end
  end

  // Owner next state: a fetch granted under flush is cancelled up front
  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_d_gnt && !d_we) begin
      w_owner_nxt = OWN_D;
    end else if (w_if_gnt && !flush) begin
      w_owner_nxt = OWN_IF;
    end else begin
      w_owner_nxt = OWN_NONE;
    end
  end

  // Starvation counter next value, saturating at the limit
  always_comb begin
    w_starve_cnt_nxt = r_starve_cnt;
    if (!if_req || w_if_gnt) begin
      w_starve_cnt_nxt = 4'd0;
    end else if (r_starve_cnt >= STARVE_LIM) begin
      w_starve_cnt_nxt = STARVE_LIM;
    end else begin
      w_starve_cnt_nxt = r_starve_cnt + 4'd1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner      <= OWN_NONE;
      r_starve_cnt <= 4'd0;
      r_starved    <= 1'b0;
      r_last_addr  <= {XLEN{1'b0}};
    end else begin
      r_owner      <= w_owner_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
      r_starved    <= (w_starve_cnt_nxt == STARVE_LIM);
      r_last_addr  <= w_ram_addr;
    end
  end

  assign if_gnt         = w_if_gnt;
  assign d_gnt          = w_d_gnt;
  assign ram_addr       = w_ram_addr;
  assign ram_write_mode = w_ram_mode;
  assign ram_wdata      = w_ram_wdata;
  assign starved        = r_starved;

  // A flush arriving with the fetch data also drops that response
  assign if_rvalid = (r_owner == OWN_IF) && !flush;
  assign d_rvalid  = (r_owner == OWN_D);
  assign if_rdata  = if_rvalid ? ram_rdata : {XLEN{1'b0}};
  assign d_rdata   = d_rvalid ? ram_rdata : {XLEN{1'b0}};

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: grant/RAM-side checks inline, responses via scoreboard queues.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, flush;
  logic [31:0] if_addr, d_addr, d_wdata, ram_rdata;
  logic [1:0]  d_wmode;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, starved;
  logic [31:0] if_rdata, d_rdata, ram_addr, ram_wdata;
  logic [1:0]  ram_write_mode;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t if_q[$];
  exp_t d_q[$];
  int   cyc_cnt = 0;
  int   n_chk   = 0;
  int   n_err   = 0;

  ram_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_wmode(d_wmode), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .flush(flush), .ram_addr(ram_addr), .ram_write_mode(ram_write_mode),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .starved(starved)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic drv(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                     input logic [1:0] dm, input logic [31:0] da, input logic [31:0] dd,
                     input logic fl, input logic [31:0] rd);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_wmode = dm;
    d_addr = da; d_wdata = dd; flush = fl; ram_rdata = rd;
  endtask

  task automatic idle(input logic [31:0] rd);
    drv(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, rd);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_if(input logic [31:0] data);
    exp_t e;
    e.due = cyc_cnt + 1; e.data = data;
    if_q.push_back(e);
  endtask

  task automatic push_d(input logic [31:0] data);
    exp_t e;
    e.due = cyc_cnt + 1; e.data = data;
    d_q.push_back(e);
  endtask

  // Response monitor: every cycle either an expected response is due or rvalid must be low
  always @(negedge clk) begin
    exp_t e;
    if (if_q.size() != 0 && if_q[0].due <= cyc_cnt) begin
      e = if_q.pop_front();
      chk("if_rvalid", {31'b0, if_rvalid}, 32'd1);
      chk("if_rdata", if_rdata, e.data);
    end else begin
      chk("if_rvalid_unexpected", {31'b0, if_rvalid}, 32'd0);
      chk("if_rdata_zero", if_rdata, 32'h0);
    end
    if (d_q.size() != 0 && d_q[0].due <= cyc_cnt) begin
      e = d_q.pop_front();
      chk("d_rvalid", {31'b0, d_rvalid}, 32'd1);
      chk("d_rdata", d_rdata, e.data);
    end else begin
      chk("d_rvalid_unexpected", {31'b0, d_rvalid}, 32'd0);
      chk("d_rdata_zero", d_rdata, 32'h0);
    end
  end

  initial begin
    logic exp_if;
    // Reset holds everything at zero even with requests active
    rst = 1'b0;
    drv(1'b1, 32'h100, 1'b1, 1'b1, 2'b11, 32'h55, 32'hFFFF_FFFF, 1'b0, 32'h1234_5678);
    @(negedge clk);
    chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
    chk("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_mode", {30'b0, ram_write_mode}, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_starved", {31'b0, starved}, 32'd0);
    next_cyc();
    rst = 1'b1;
    idle(32'h0);
    @(negedge clk);
    next_cyc();

    // Fetch alone
    drv(1'b1, 32'h100, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    push_if(32'hDEAD_BEEF);
    @(negedge clk);
    chk("fetch_if_gnt", {31'b0, if_gnt}, 32'd1);
    chk("fetch_d_gnt", {31'b0, d_gnt}, 32'd0);
    chk("fetch_ram_addr", ram_addr, 32'h100);
    chk("fetch_ram_mode", {30'b0, ram_write_mode}, 32'd0);
    next_cyc();
    idle(32'hDEAD_BEEF);
    @(negedge clk);
    chk("idle_hold_addr", ram_addr, 32'h100);
    chk("idle_if_gnt", {31'b0, if_gnt}, 32'd0);
    next_cyc();

    // Collision: data wins, fetch follows back-to-back
    drv(1'b1, 32'h104, 1'b1, 1'b0, 2'b00, 32'h200, 32'h0, 1'b0, 32'h0);
    push_d(32'h1111_2222);
    @(negedge clk);
    chk("coll_d_gnt", {31'b0, d_gnt}, 32'd1);
    chk("coll_if_gnt", {31'b0, if_gnt}, 32'd0);
    chk("coll_ram_addr", ram_addr, 32'h200);
    next_cyc();
    drv(1'b1, 32'h104, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h1111_2222);
    push_if(32'h3333_4444);
    @(negedge clk);
    chk("coll_if_gnt2", {31'b0, if_gnt}, 32'd1);
    chk("coll_ram_addr2", ram_addr, 32'h104);
    next_cyc();
    idle(32'h3333_4444);
    @(negedge clk);
    next_cyc();

    // Starvation: loads held for 10 cycles against a waiting fetch
    for (int i = 0; i < 10; i++) begin
      exp_if = (i == 4) || (i == 9);
      drv(1'b1, 32'h180, 1'b1, 1'b0, 2'b00, 32'h40 + i, 32'h0, 1'b0, 32'hC000_0000 | i);
      if (exp_if) push_if(32'hC000_0000 | (i + 1));
      else        push_d(32'hC000_0000 | (i + 1));
      @(negedge clk);
      chk("starve_if_gnt", {31'b0, if_gnt}, {31'b0, exp_if});
      chk("starve_d_gnt", {31'b0, d_gnt}, {31'b0, ~exp_if});
      chk("starve_flag", {31'b0, starved}, {31'b0, exp_if});
      chk("starve_ram_addr", ram_addr, exp_if ? 32'h180 : (32'h40 + i));
      next_cyc();
    end
    idle(32'hC000_000A);
    @(negedge clk);
    chk("starve_cleared", {31'b0, starved}, 32'd0);
    next_cyc();

    // Byte store, then a store that writes nothing, then a load carrying a stray wmode
    drv(1'b0, 32'h0, 1'b1, 1'b1, 2'b01, 32'h3, 32'hAB, 1'b0, 32'h0);
    @(negedge clk);
    chk("st_d_gnt", {31'b0, d_gnt}, 32'd1);
    chk("st_ram_mode", {30'b0, ram_write_mode}, 32'd1);
    chk("st_ram_addr", ram_addr, 32'h3);
    chk("st_ram_wdata", ram_wdata, 32'hAB);
    next_cyc();
    drv(1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 32'h8, 32'hFF, 1'b0, 32'h0);
    @(negedge clk);
    chk("st0_d_gnt", {31'b0, d_gnt}, 32'd1);
    chk("st0_ram_mode", {30'b0, ram_write_mode}, 32'd0);
    chk("st0_ram_addr", ram_addr, 32'h8);
    next_cyc();
    drv(1'b0, 32'h0, 1'b1, 1'b0, 2'b11, 32'hC, 32'h0, 1'b0, 32'h0);
    push_d(32'h0BAD_F00D);
    @(negedge clk);
    chk("ld_ram_mode", {30'b0, ram_write_mode}, 32'd0);
    next_cyc();
    idle(32'h0BAD_F00D);
    @(negedge clk);
    chk("st_idle_mode", {30'b0, ram_write_mode}, 32'd0);
    chk("st_idle_hold", ram_addr, 32'hC);
    next_cyc();

    // Flush in the response cycle; concurrent load unaffected
    drv(1'b1, 32'h1C0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("fl_if_gnt", {31'b0, if_gnt}, 32'd1);
    next_cyc();
    drv(1'b0, 32'h0, 1'b1, 1'b0, 2'b00, 32'h240, 32'h0, 1'b1, 32'h77);
    push_d(32'h88);
    @(negedge clk);
    chk("fl_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("fl_d_gnt", {31'b0, d_gnt}, 32'd1);
    next_cyc();
    idle(32'h88);
    @(negedge clk);
    next_cyc();

    // Flush in the grant cycle cancels the fetch
    drv(1'b1, 32'h1C4, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'h0);
    @(negedge clk);
    chk("flg_if_gnt", {31'b0, if_gnt}, 32'd1);
    next_cyc();
    idle(32'h99);
    @(negedge clk);
    chk("flg_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    next_cyc();

    // Reset right after a load grant discards the response
    drv(1'b0, 32'h0, 1'b1, 1'b0, 2'b00, 32'h2C0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("rl_d_gnt", {31'b0, d_gnt}, 32'd1);
    next_cyc();
    rst = 1'b0;
    drv(1'b1, 32'h300, 1'b1, 1'b1, 2'b10, 32'h304, 32'h5555, 1'b0, 32'h1234);
    #1;
    chk("rl_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    chk("rl_d_rdata", d_rdata, 32'h0);
    chk("rl_if_gnt", {31'b0, if_gnt}, 32'd0);
    chk("rl_d_gnt0", {31'b0, d_gnt}, 32'd0);
    chk("rl_ram_addr", ram_addr, 32'h0);
    chk("rl_ram_mode", {30'b0, ram_write_mode}, 32'd0);
    chk("rl_ram_wdata", ram_wdata, 32'h0);
    @(negedge clk);
    next_cyc();
    rst = 1'b1;
    idle(32'h1234);
    @(negedge clk);
    chk("rl_rel_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    next_cyc();
    idle(32'h1234);
    @(negedge clk);
    chk("rl_post_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    next_cyc();
    @(negedge clk);

    chk("if_q_drained", if_q.size(), 32'd0);
    chk("d_q_drained", d_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
